noc_traffic_injector: RTL and testbench

// Synthesizable per-router packet generator that replaces file-driven local-port stimulus for NoC

---
 rtl/noc_traffic_injector.sv | 223 ++++++++++++++++++++++
 tb/tb_noc_traffic_injector.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_injector.sv
`default_nettype none
// ============================================================================
// Module      : noc_traffic_injector
// Description : Per-router packet generator. Descriptors (time, target, size)
//               are queued in a small FIFO. Each descriptor is launched once the
//               free-running cycle counter passes its time. It is then
//               serialised as header, size, timestamp, packet number and payload
//               flits onto a credit-controlled router Local input port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock_rx    in   1            injection clock
//   reset       in   1            synchronous, active-high
//   desc_valid  in   1            descriptor offered
//   desc_ready  out  1            descriptor FIFO not full
//   desc_time   in   32           launch once cycle_count > desc_time
//   desc_tgt_x  in   COORD_WIDTH  target x coordinate
//   desc_tgt_y  in   COORD_WIDTH  target y coordinate
//   desc_size   in   SIZE_WIDTH   flits following the size flit
//   tx          out  1            flit valid toward router Local rx
//   data_out    out  FLIT_WIDTH   flit data (zero while tx is low)
//   credit_i    in   1            flit transfers on an edge with tx && credit_i
//   cycle_count out  32           free-running cycle counter
//   pkt_sent    out  16           packets fully transmitted
//   busy        out  1            packet in flight or descriptors queued
// ============================================================================
module noc_traffic_injector #(
  parameter int FLIT_WIDTH  = 32,
  parameter int COORD_WIDTH = 8,
  parameter int SIZE_WIDTH  = 16,
  parameter int DESC_DEPTH  = 4,
  parameter int ROUTER_ID   = 0,
  parameter int POS_X       = 0,
  parameter int POS_Y       = 0
) (
  input  logic                   clock_rx,
  input  logic                   reset,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [31:0]            desc_time,
  input  logic [COORD_WIDTH-1:0] desc_tgt_x,
  input  logic [COORD_WIDTH-1:0] desc_tgt_y,
  input  logic [SIZE_WIDTH-1:0]  desc_size,
  output logic                   tx,
  output logic [FLIT_WIDTH-1:0]  data_out,
  input  logic                   credit_i,
  output logic [31:0]            cycle_count,
  output logic [15:0]            pkt_sent,
  output logic                   busy
);

  localparam int                     c_aw            = $clog2(DESC_DEPTH);
  localparam logic [c_aw:0]          c_ptr_one       = (c_aw + 1)'(1);
  localparam logic [COORD_WIDTH-1:0] c_pos_x         = COORD_WIDTH'(POS_X);
  localparam logic [COORD_WIDTH-1:0] c_pos_y         = COORD_WIDTH'(POS_Y);
  localparam logic [63:0]            c_pktnum_base   = 64'(ROUTER_ID) * 64'd10000000;
  localparam logic [SIZE_WIDTH-1:0]  c_min_size      = SIZE_WIDTH'(2);
  localparam logic [SIZE_WIDTH-1:0]  c_first_payload = SIZE_WIDTH'(3);
  localparam logic [SIZE_WIDTH-1:0]  c_size_one      = SIZE_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_SIZE    = 3'd2,
    S_STAMP   = 3'd3,
    S_PKTNUM  = 3'd4,
    S_PAYLOAD = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Descriptor FIFO storage and pointers (extra MSB distinguishes full/empty)
  logic [31:0]            r_fifo_time [DESC_DEPTH];
  logic [COORD_WIDTH-1:0] r_fifo_x    [DESC_DEPTH];
  logic [COORD_WIDTH-1:0] r_fifo_y    [DESC_DEPTH];
  logic [SIZE_WIDTH-1:0]  r_fifo_size [DESC_DEPTH];
  logic [c_aw:0]          r_wr_ptr;
  logic [c_aw:0]          r_rd_ptr;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_launch;
  logic                   w_pkt_done;
  logic [31:0]            w_head_time;
  logic [COORD_WIDTH-1:0] w_head_x;
  logic [COORD_WIDTH-1:0] w_head_y;
  logic [SIZE_WIDTH-1:0]  w_head_size;

  // Working registers for the packet in flight
  logic [31:0]            r_cycle_count;
  logic [15:0]            r_pkt_sent;
  logic [31:0]            r_time;
  logic [COORD_WIDTH-1:0] r_tgt_x;
  logic [COORD_WIDTH-1:0] r_tgt_y;
  logic [SIZE_WIDTH-1:0]  r_eff_size;
  logic [31:0]            r_stamp;
  logic [SIZE_WIDTH-1:0]  r_pay_idx;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_push      = desc_valid && !w_full;
  assign w_head_time = r_fifo_time[r_rd_ptr[c_aw-1:0]];
  assign w_head_x    = r_fifo_x[r_rd_ptr[c_aw-1:0]];
  assign w_head_y    = r_fifo_y[r_rd_ptr[c_aw-1:0]];
  assign w_head_size = r_fifo_size[r_rd_ptr[c_aw-1:0]];

  // Only the head is considered; a future-dated head blocks everything behind it.
  assign w_launch    = !w_empty && (r_cycle_count > w_head_time);

  assign desc_ready  = !w_full;
  assign cycle_count = r_cycle_count;
  assign pkt_sent    = r_pkt_sent;
  assign busy        = (r_state != S_IDLE) || !w_empty;

  always_ff @(posedge clock_rx) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clock_rx) begin
    if (w_push) begin
      r_fifo_time[r_wr_ptr[c_aw-1:0]] <= desc_time;
      r_fifo_x[r_wr_ptr[c_aw-1:0]]    <= desc_tgt_x;
      r_fifo_y[r_wr_ptr[c_aw-1:0]]    <= desc_tgt_y;
      r_fifo_size[r_wr_ptr[c_aw-1:0]] <= desc_size;
    end
  end

  // FSM state register
  always_ff @(posedge clock_rx) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state and flit outputs; IDLE always drives tx=0, data_out=0.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_pkt_done   = 1'b0;
    tx           = 1'b0;
    data_out     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_pop        = 1'b1;
          w_next_state = S_HEADER;
        end
      end
      S_HEADER: begin
        tx       = 1'b1;
        data_out = FLIT_WIDTH'({c_pos_x, c_pos_y, r_tgt_x, r_tgt_y});
        if (credit_i) w_next_state = S_SIZE;
      end
      S_SIZE: begin
        tx       = 1'b1;
        data_out = FLIT_WIDTH'(r_eff_size);
        if (credit_i) w_next_state = S_STAMP;
      end
      S_STAMP: begin
        tx       = 1'b1;
        data_out = FLIT_WIDTH'(r_stamp);
        if (credit_i) w_next_state = S_PKTNUM;
      end
      S_PKTNUM: begin
        tx       = 1'b1;
        data_out = FLIT_WIDTH'(c_pktnum_base + 64'(r_time));
        if (credit_i) begin
          if (r_eff_size == c_min_size) begin
            w_next_state = S_IDLE;
            w_pkt_done   = 1'b1;
          end else begin
            w_next_state = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        tx       = 1'b1;
        data_out = FLIT_WIDTH'(r_pay_idx);
        if (credit_i && (r_pay_idx == r_eff_size)) begin
          w_next_state = S_IDLE;
          w_pkt_done   = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_rx) begin
    if (reset) begin
      r_cycle_count <= '0;
      r_pkt_sent    <= '0;
    end else begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (w_pkt_done) r_pkt_sent <= r_pkt_sent + 16'd1;
    end
  end

  always_ff @(posedge clock_rx) begin
    if (w_pop) begin
      r_time     <= w_head_time;
      r_tgt_x    <= w_head_x;
      r_tgt_y    <= w_head_y;
      // Packets always carry at least the timestamp and packet-number flits.
      r_eff_size <= (w_head_size < c_min_size) ? c_min_size : w_head_size;
    end
    // Timestamp is the counter value at the edge that moves SIZE into STAMP.
    if ((r_state == S_SIZE) && credit_i)    r_stamp   <= r_cycle_count;
    // Payload flit values continue the flit index, starting at 3.
    if ((r_state == S_PKTNUM) && credit_i)  r_pay_idx <= c_first_payload;
    if ((r_state == S_PAYLOAD) && credit_i) r_pay_idx <= r_pay_idx + c_size_one;
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_traffic_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_traffic_injector
// Description : Directed self-checking bench for noc_traffic_injector
//               (ROUTER_ID=5, POS=(1,2), DESC_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_traffic_injector;

  logic        clock_rx   = 1'b0;
  logic        reset      = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_time  = '0;
  logic [7:0]  desc_tgt_x = '0;
  logic [7:0]  desc_tgt_y = '0;
  logic [15:0] desc_size  = '0;
  logic        tx;
  logic [31:0] data_out;
  logic        credit_i   = 1'b0;
  logic [31:0] cycle_count;
  logic [15:0] pkt_sent;
  logic        busy;

  int checks = 0;
  int errors = 0;

  noc_traffic_injector #(
    .FLIT_WIDTH (32),
    .COORD_WIDTH(8),
    .SIZE_WIDTH (16),
    .DESC_DEPTH (4),
    .ROUTER_ID  (5),
    .POS_X      (1),
    .POS_Y      (2)
  ) dut (
    .clock_rx   (clock_rx),
    .reset      (reset),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_time  (desc_time),
    .desc_tgt_x (desc_tgt_x),
    .desc_tgt_y (desc_tgt_y),
    .desc_size  (desc_size),
    .tx         (tx),
    .data_out   (data_out),
    .credit_i   (credit_i),
    .cycle_count(cycle_count),
    .pkt_sent   (pkt_sent),
    .busy       (busy)
  );

  always #5 clock_rx = ~clock_rx;

  // Reference cycle counter
  int unsigned m_cc = 0;
  always @(posedge clock_rx) begin
    if (reset) m_cc <= 0;
    else       m_cc <= m_cc + 1;
  end

  // Flit monitor: transfers, tx rising cycles, nonzero data while idle
  logic [31:0] mon_data [$];
  int unsigned mon_cc   [$];
  int unsigned mon_rise [$];
  logic        prev_tx  = 1'b0;
  int          zero_err = 0;
  always @(negedge clock_rx) begin
    if (tx && credit_i) begin
      mon_data.push_back(data_out);
      mon_cc.push_back(m_cc);
    end
    if (tx && !prev_tx) mon_rise.push_back(m_cc);
    if (!tx && (data_out !== 32'h0)) zero_err <= zero_err + 1;
    prev_tx <= tx;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_rx);
    #1;
  endtask

  task automatic clear_mon;
    mon_data.delete();
    mon_cc.delete();
    mon_rise.delete();
  endtask

  task automatic do_reset;
    @(posedge clock_rx);
    #1;
    reset      = 1'b1;
    desc_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic push_desc(input logic [31:0] t, input logic [7:0] x, input logic [7:0] y,
                           input logic [15:0] s);
    bit ok = 0;
    desc_time  = t;
    desc_tgt_x = x;
    desc_tgt_y = y;
    desc_size  = s;
    desc_valid = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clock_rx);
      if (desc_ready) ok = 1;
      @(posedge clock_rx);
      #1;
    end
    desc_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: desc time=%0d not accepted, desc_ready=%0b required 1", t, desc_ready);
    end
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int n = 0;
    @(negedge clock_rx);
    while ((busy || tx) && n < maxc) begin
      @(negedge clock_rx);
      n++;
    end
    checks++;
    if (busy || tx) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0b tx=%0b required 0 0", name, busy, tx);
    end
    @(posedge clock_rx);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clock_rx);
    #1;
    reset = 1'b1;
    tick(2);
    @(negedge clock_rx);
    checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL rst_desc_ready: got %0b required 1", desc_ready); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rst_tx: got %0b required 0", tx); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data_out: got %0h required 0", data_out); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle_count: got %0d required 0", cycle_count); end
    checks++; if (pkt_sent !== 16'd0) begin errors++; $display("FAIL rst_pkt_sent: got %0d required 0", pkt_sent); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
    @(posedge clock_rx);
    #1;
    reset = 1'b0;
    tick(5);
    @(negedge clock_rx);
    checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL cycle_count_run: got %0d required 5", cycle_count); end
  endtask

  task automatic test_single;
    logic [31:0] exp_f [6];
    exp_f = '{32'h01020304, 32'd4, 32'd13, 32'd50000010, 32'd3, 32'd4};
    do_reset();
    credit_i = 1'b1;
    push_desc(32'd10, 8'd3, 8'd4, 16'd4);
    wait_idle(100, "single");
    checks++;
    if (mon_rise.size() != 1 || mon_rise[0] != 12) begin
      errors++;
      $display("FAIL single_rise: got %0d rises first at %0d required 1 at 12", mon_rise.size(),
               (mon_rise.size() > 0) ? mon_rise[0] : 0);
    end
    checks++;
    if (mon_data.size() != 6) begin errors++; $display("FAIL single_len: got %0d required 6", mon_data.size()); end
    for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
      checks++;
      if (mon_data[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL single_flit%0d: got %0h required %0h", i, mon_data[i], exp_f[i]);
      end
    end
    checks++; if (pkt_sent !== 16'd1) begin errors++; $display("FAIL single_pkt_sent: got %0d required 1", pkt_sent); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_f [6];
    logic [31:0] prev_d = '0;
    logic        prev_stall = 1'b0;
    int          stall_err = 0;
    int          stall_cnt = 0;
    int          n = 0;
    exp_f = '{32'h01020304, 32'd4, 32'd4, 32'd50000000, 32'd3, 32'd4};
    do_reset();
    credit_i = 1'b0;
    push_desc(32'd0, 8'd3, 8'd4, 16'd4);
    while (n < 100) begin
      @(negedge clock_rx);
      if (prev_stall && (!tx || data_out !== prev_d)) stall_err++;
      prev_stall = tx && !credit_i;
      if (prev_stall) stall_cnt++;
      prev_d = data_out;
      if (!busy && !tx) break;
      @(posedge clock_rx);
      #1;
      credit_i = ~credit_i;
      n++;
    end
    @(posedge clock_rx);
    #1;
    credit_i = 1'b1;
    checks++; if (n >= 100) begin errors++; $display("FAIL bp_timeout: cycles %0d required < 100", n); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_hold: unstable stalled cycles %0d required 0", stall_err); end
    checks++; if (stall_cnt < 3) begin errors++; $display("FAIL bp_stalls: stalled cycles %0d required >= 3", stall_cnt); end
    checks++;
    if (mon_data.size() != 6) begin errors++; $display("FAIL bp_len: got %0d required 6", mon_data.size()); end
    for (int i = 0; i < 6 && i < mon_data.size(); i++) begin
      checks++;
      if (mon_data[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL bp_flit%0d: got %0h required %0h", i, mon_data[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_fifo_full;
    int idx = 0;
    bit acc;
    do_reset();
    credit_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      desc_valid = 1'b1;
      desc_time  = 32'(idx + 1);
      desc_tgt_x = 8'(idx);
      desc_tgt_y = 8'(idx);
      desc_size  = 16'd2;
      acc = 0;
      @(negedge clock_rx);
      if (desc_ready) acc = 1;
      @(posedge clock_rx);
      #1;
      if (acc) idx++;
    end
    @(negedge clock_rx);
    checks++; if (idx != 5) begin errors++; $display("FAIL full_accepted: got %0d required 5", idx); end
    checks++; if (desc_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b required 0", desc_ready); end
    @(posedge clock_rx);
    #1;
    credit_i = 1'b1;
    push_desc(32'd6, 8'd5, 8'd5, 16'd2);
    wait_idle(200, "full");
    checks++; if (pkt_sent !== 16'd6) begin errors++; $display("FAIL full_pkt_sent: got %0d required 6", pkt_sent); end
    checks++;
    if (mon_data.size() != 24) begin errors++; $display("FAIL full_len: got %0d required 24", mon_data.size()); end
    for (int i = 0; i < 6 && (4 * i + 3) < mon_data.size(); i++) begin
      logic [31:0] exp_h;
      logic [31:0] exp_p;
      exp_h = 32'h01020000 | (32'(i) << 8) | 32'(i);
      exp_p = 32'd50000001 + 32'(i);
      checks++;
      if (mon_data[4 * i] !== exp_h || mon_data[4 * i + 3] !== exp_p) begin
        errors++;
        $display("FAIL full_pkt%0d: got hdr %0h num %0d required hdr %0h num %0d",
                 i, mon_data[4 * i], mon_data[4 * i + 3], exp_h, exp_p);
      end
    end
  endtask

  task automatic test_size_clamp;
    logic [31:0] exp_f [4];
    exp_f = '{32'h01020709, 32'd2, 32'd103, 32'd50000100};
    do_reset();
    credit_i = 1'b1;
    push_desc(32'd100, 8'd7, 8'd9, 16'd0);
    wait_idle(300, "clamp");
    checks++;
    if (mon_data.size() != 4) begin errors++; $display("FAIL clamp_len: got %0d required 4", mon_data.size()); end
    for (int i = 0; i < 4 && i < mon_data.size(); i++) begin
      checks++;
      if (mon_data[i] !== exp_f[i]) begin
        errors++;
        $display("FAIL clamp_flit%0d: got %0h required %0h", i, mon_data[i], exp_f[i]);
      end
    end
    checks++; if (pkt_sent !== 16'd1) begin errors++; $display("FAIL clamp_pkt_sent: got %0d required 1", pkt_sent); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    credit_i = 1'b1;
    push_desc(32'd200, 8'd1, 8'd1, 16'd3);
    push_desc(32'd0, 8'd2, 8'd2, 16'd2);
    tick(199);
    @(negedge clock_rx);
    checks++;
    if (mon_data.size() != 0 || tx !== 1'b0) begin
      errors++;
      $display("FAIL b2b_early: flits %0d tx %0b at cycle %0d required 0 0", mon_data.size(), tx, m_cc);
    end
    wait_idle(100, "b2b");
    checks++;
    if (mon_rise.size() != 2 || mon_rise[0] != 202 || mon_rise[1] != 208) begin
      errors++;
      $display("FAIL b2b_rise: got %0d rises at %0d,%0d required 2 at 202,208", mon_rise.size(),
               (mon_rise.size() > 0) ? mon_rise[0] : 0, (mon_rise.size() > 1) ? mon_rise[1] : 0);
    end
    checks++;
    if (mon_data.size() != 9) begin
      errors++;
      $display("FAIL b2b_len: got %0d required 9", mon_data.size());
    end else begin
      checks++;
      if (mon_data[3] !== 32'd50000200 || mon_data[4] !== 32'd3 || mon_data[5] !== 32'h01020202 ||
          mon_data[8] !== 32'd50000000) begin
        errors++;
        $display("FAIL b2b_flits: got %0h %0h %0h %0h required 2faf148 3 1020202 2faf080",
                 mon_data[3], mon_data[4], mon_data[5], mon_data[8]);
      end
    end
    checks++; if (pkt_sent !== 16'd2) begin errors++; $display("FAIL b2b_pkt_sent: got %0d required 2", pkt_sent); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    do_reset();
    credit_i = 1'b1;
    push_desc(32'd0, 8'd1, 8'd1, 16'd8);
    push_desc(32'd0, 8'd2, 8'd2, 16'd2);
    @(negedge clock_rx);
    while (mon_data.size() < 5 && n < 50) begin
      @(negedge clock_rx);
      n++;
    end
    checks++; if (mon_data.size() < 5) begin errors++; $display("FAIL mid_reach: flits %0d required 5", mon_data.size()); end
    @(posedge clock_rx);
    #1;
    reset = 1'b1;
    @(posedge clock_rx);
    @(negedge clock_rx);
    checks++;
    if (tx !== 1'b0 || pkt_sent !== 16'd0 || busy !== 1'b0 || desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: tx %0b pkt_sent %0d busy %0b ready %0b required 0 0 0 1",
               tx, pkt_sent, busy, desc_ready);
    end
    @(posedge clock_rx);
    #1;
    reset = 1'b0;
    clear_mon();
    push_desc(32'd0, 8'd5, 8'd6, 16'd3);
    wait_idle(100, "mid");
    checks++;
    if (mon_data.size() != 5) begin
      errors++;
      $display("FAIL mid_len: got %0d required 5", mon_data.size());
    end else begin
      checks++;
      if (mon_data[0] !== 32'h01020506 || mon_data[4] !== 32'd3) begin
        errors++;
        $display("FAIL mid_flits: got %0h %0h required 1020506 3", mon_data[0], mon_data[4]);
      end
    end
    checks++; if (pkt_sent !== 16'd1) begin errors++; $display("FAIL mid_pkt_sent: got %0d required 1", pkt_sent); end
  endtask

  task automatic test_idle_zero;
    checks++;
    if (zero_err != 0) begin errors++; $display("FAIL idle_data_zero: cycles %0d required 0", zero_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fifo_full();
    test_size_clamp();
    test_back_to_back();
    test_reset_mid();
    test_idle_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
